// File: rtl/ps_link_arbiter.sv
// ---------------------------------------------------------------------------
// ps_link_arbiter
//
// Two requesters share one 4-bit parallel-to-serial shifter. Each accepted
// word is sent on a single serial line as a framed sequence:
//   start(1), channel id, d3, d2, d1, d0, then one idle gap bit (0).
// Arbitration is round-robin over the two requesters. Every state, the shift
// register and the bit counter advance only on clock edges where en=1.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-low reset
//   en     in   bit-time enable
//   req0   in   requester 0 word pending (held until gnt0)
//   data0  in   requester 0 word, stable while req0=1
//   req1   in   requester 1 word pending (held until gnt1)
//   data1  in   requester 1 word, stable while req1=1
//   gnt0   out  one-cycle pulse, data0 captured
//   gnt1   out  one-cycle pulse, data1 captured
//   sout   out  serial line, idle level 0
//   frame  out  high while sout carries start/id/data bits
//   busy   out  high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module ps_link_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       req0,
    input  logic [3:0] data0,
    input  logic       req1,
    input  logic [3:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       sout,
    output logic       frame,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ID    = 3'd2,
        ST_DATA  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t     state_r;
    logic [3:0] shift_r;
    logic [1:0] cnt_r;
    logic       id_r;
    logic       last_r;

    logic       any_req_s;
    logic       pick1_s;
    logic [3:0] win_data_s;

    // Round-robin winner selection; on a tie the requester that did not
    // win last time is chosen.
    always_comb begin
        any_req_s  = req0 | req1;
        pick1_s    = 1'b0;
        win_data_s = data0;
        if (req1 && (!req0 || !last_r)) begin
            pick1_s    = 1'b1;
            win_data_s = data1;
        end else begin
            pick1_s    = 1'b0;
            win_data_s = data0;
        end
    end

    // Frame sequencer. Outputs are registered with the value belonging to
    // the state being entered, so sout/frame line up with the state cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            shift_r <= 4'd0;
            cnt_r   <= 2'd0;
            id_r    <= 1'b0;
            last_r  <= 1'b1;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            sout    <= 1'b0;
            frame   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            // Grants are pulses: cleared every cycle, even when en=0.
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            if (en) begin
                case (state_r)
                    ST_IDLE: begin
                        if (any_req_s) begin
                            state_r <= ST_START;
                            shift_r <= win_data_s;
                            id_r    <= pick1_s;
                            last_r  <= pick1_s;
                            gnt0    <= ~pick1_s;
                            gnt1    <= pick1_s;
                            sout    <= 1'b1;
                            frame   <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            sout    <= 1'b0;
                            frame   <= 1'b0;
                            busy    <= 1'b0;
                        end
                    end
                    ST_START: begin
                        state_r <= ST_ID;
                        sout    <= id_r;
                        frame   <= 1'b1;
                    end
                    ST_ID: begin
                        state_r <= ST_DATA;
                        cnt_r   <= 2'd0;
                        sout    <= shift_r[3];
                        frame   <= 1'b1;
                    end
                    ST_DATA: begin
                        shift_r <= {shift_r[2:0], 1'b0};
                        cnt_r   <= cnt_r + 2'd1;
                        if (cnt_r == 2'd3) begin
                            state_r <= ST_GAP;
                            sout    <= 1'b0;
                            frame   <= 1'b0;
                        end else begin
                            // shift_r[2] becomes the MSB after this shift.
                            sout    <= shift_r[2];
                            frame   <= 1'b1;
                        end
                    end
                    ST_GAP: begin
                        state_r <= ST_IDLE;
                        sout    <= 1'b0;
                        frame   <= 1'b0;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 2'd0;
                        sout    <= 1'b0;
                        frame   <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps_link_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ps_link_arbiter
//
// Directed self-checking bench for ps_link_arbiter. Each task drives one
// scenario and compares the packed output vector
// {gnt0, gnt1, sout, frame, busy} against hand-derived expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_ps_link_arbiter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       req0;
    logic [3:0] data0;
    logic       req1;
    logic [3:0] data1;
    logic       gnt0;
    logic       gnt1;
    logic       sout;
    logic       frame;
    logic       busy;

    int checks;
    int errors;

    ps_link_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .req0  (req0),
        .data0 (data0),
        .req1  (req1),
        .data1 (data1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .sout  (sout),
        .frame (frame),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] obs();
        return {gnt0, gnt1, sout, frame, busy};
    endfunction

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; req0 = 1'b1; req1 = 1'b1;
        data0 = 4'hF; data1 = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs() !== 5'b00000) begin
                errors++;
                $display("FAIL reset cyc%0d got=%b exp=%b", i, obs(), 5'b00000);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (obs() !== 5'b00000) begin
                errors++;
                $display("FAIL idle cyc%0d got=%b exp=%b", i, obs(), 5'b00000);
            end
        end
    endtask

    task automatic test_single();
        logic [4:0] exp_v [0:7];
        exp_v = '{5'b10111, 5'b00011, 5'b00111, 5'b00011,
                  5'b00111, 5'b00111, 5'b00001, 5'b00000};
        req0 = 1'b1; data0 = 4'b1011;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) req0 = 1'b0;
            checks++;
            if (obs() !== exp_v[i]) begin
                errors++;
                $display("FAIL single cyc%0d got=%b exp=%b", i, obs(), exp_v[i]);
            end
        end
    endtask

    task automatic test_alternate();
        logic [4:0] e;
        logic [3:0] d;
        logic       id;
        int         p;
        reset = 1'b0;
        step();
        reset = 1'b1;
        req0 = 1'b1; data0 = 4'hA;
        req1 = 1'b1; data1 = 4'h5;
        for (int i = 0; i < 32; i++) begin
            step();
            p  = i % 8;
            id = ((i / 8) % 2) == 1;
            d  = id ? 4'h5 : 4'hA;
            e  = 5'b00000;
            e[4] = (p == 0) && !id;
            e[3] = (p == 0) && id;
            if (p == 0)                e[2] = 1'b1;
            else if (p == 1)           e[2] = id;
            else if (p >= 2 && p <= 5) e[2] = d[5 - p];
            else                       e[2] = 1'b0;
            e[1] = (p < 6);
            e[0] = (p < 7);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL alternate cyc%0d got=%b exp=%b", i, obs(), e);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_en_toggle();
        logic [4:0] exp_v [0:7];
        // Per frame phase: START, ID(=1), d3=1, d2=1, d1=0, d0=0, GAP, IDLE.
        exp_v = '{5'b01111, 5'b00111, 5'b00111, 5'b00111,
                  5'b00011, 5'b00011, 5'b00001, 5'b00000};
        req1 = 1'b1; data1 = 4'b1100;
        for (int i = 0; i < 15; i++) begin
            en = (i % 2) == 0;
            step();
            if (i == 0) req1 = 1'b0;
            checks++;
            if (i == 1) begin
                if (obs() !== 5'b00111) begin
                    errors++;
                    $display("FAIL en_toggle cyc%0d got=%b exp=%b", i, obs(), 5'b00111);
                end
            end else if (obs() !== exp_v[i / 2]) begin
                errors++;
                $display("FAIL en_toggle cyc%0d got=%b exp=%b", i, obs(), exp_v[i / 2]);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [2:0] e;
        logic [2:0] o;
        req0 = 1'b1; data0 = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) req0 = 1'b0;
            if (i == 2) begin
                req1 = 1'b1; data1 = 4'b0101;
            end
            if (i == 8) req1 = 1'b0;
            o = {gnt0, gnt1, busy};
            if (i == 0)      e = 3'b101;
            else if (i < 7)  e = 3'b001;
            else if (i == 7) e = 3'b000;
            else if (i == 8) e = 3'b011;
            else             e = 3'b001;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_gnt cyc%0d got=%b exp=%b", i, o, e);
            end
            if (i == 8 || i == 9) begin
                checks++;
                if (sout !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_sout cyc%0d got=%b exp=%b", i, sout, 1'b1);
                end
            end
        end
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic run_mid(input logic with_req0);
        logic [4:0] exp_v [0:4];
        logic [4:0] w;
        exp_v = '{5'b10111, 5'b00011, 5'b00011, 5'b00111, 5'b00111};
        req0 = 1'b1; data0 = 4'b0110; req1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) begin
                req0 = 1'b0; req1 = 1'b1; data1 = 4'b1001;
            end
            checks++;
            if (obs() !== exp_v[i]) begin
                errors++;
                $display("FAIL mid_pre r0=%0b cyc%0d got=%b exp=%b", with_req0, i, obs(), exp_v[i]);
            end
        end
        // Reset during the third data bit, held for two edges with requests up.
        reset = 1'b0;
        req0 = with_req0; data0 = 4'b0110;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs() !== 5'b00000) begin
                errors++;
                $display("FAIL mid_reset r0=%0b cyc%0d got=%b exp=%b", with_req0, i, obs(), 5'b00000);
            end
        end
        reset = 1'b1;
        step();
        req0 = 1'b0; req1 = 1'b0;
        w = with_req0 ? 5'b10111 : 5'b01111;
        checks++;
        if (obs() !== w) begin
            errors++;
            $display("FAIL mid_regrant r0=%0b got=%b exp=%b", with_req0, obs(), w);
        end
        step();
        checks++;
        if (sout !== ~with_req0) begin
            errors++;
            $display("FAIL mid_id r0=%0b got=%b exp=%b", with_req0, sout, ~with_req0);
        end
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (obs() !== 5'b00000) begin
            errors++;
            $display("FAIL mid_end r0=%0b got=%b exp=%b", with_req0, obs(), 5'b00000);
        end
    endtask

    task automatic test_reset_mid();
        run_mid(1'b0);
        run_mid(1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0; en = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        data0 = 4'h0; data1 = 4'h0;
        test_reset();
        test_idle();
        test_single();
        test_alternate();
        test_en_toggle();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps_link_arbiter.md
# ps_link_arbiter

Shares one 4-bit parallel-to-serial shifter between two requesters and sequences the framed bit stream onto a single serial line. Each accepted word goes out as a 6-bit frame: start bit, channel-id bit, then data MSB first, followed by one idle gap bit. The block sits between two word-producing agents and the serial output pin. It owns arbitration (round-robin), shifter load/shift control and frame sequencing.

## Interface
Parameters:
- none; word width is fixed at 4, frame length at 6 bits plus 1 gap bit.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-low reset, sampled on posedge clk.
- en  in  1  bit-time enable; FSM, shifter and counter advance only on edges where en=1.
- req0  in  1  requester 0 has a word pending; held high until gnt0.
- data0  in  4  requester 0 word; stable while req0=1.
- req1  in  1  requester 1 request; same rules as req0.
- data1  in  4  requester 1 word.
- gnt0  out  1  one-cycle registered pulse: data0 captured.
- gnt1  out  1  one-cycle registered pulse: data1 captured.
- sout  out  1  serial line, registered; idle level 0.
- frame  out  1  high while sout carries start/id/data bits, registered, aligned with sout.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, START, ID, DATA, GAP. 2-bit bit counter for DATA. 4-bit shift register. 1-bit id register. 1-bit last-grant pointer `last`.
- IDLE: on an en=1 edge with req0|req1, choose the winner, load the shift register with its data, set id (0 or 1), set last := winner, pulse gnt, go to START. No request means stay in IDLE with sout=0 and frame=0.
- Arbitration:
  - Only one request present: that requester wins.
  - Both present: the requester that is not `last` wins.
  - `last` resets to 1, so requester 0 wins the first tie.
- START: sout=1, frame=1. Next state is ID.
- ID: sout=id, frame=1. Next state is DATA with counter=0.
- DATA: sout=shift[3], frame=1. Each en edge shifts left, inserting 0, and increments the counter. After the 4th bit (counter=3) go to GAP.
- GAP: sout=0, frame=0, busy=1. Next state is IDLE.
- en=0 freezes state, counter, shift register, sout and frame. gnt is still a single-cycle pulse and never stretches.
- Request inputs are ignored outside IDLE. A requester may change data/req in the cycle after its gnt.
- gnt0 and gnt1 are never high together.

## Timing
- Reset values: sout=0, frame=0, busy=0, gnt0=0, gnt1=0, state=IDLE, last=1, shift=0, counter=0.
- Continuous en=1, request sampled at edge E0:
  - cycle after E0: gnt=1, sout=1 (start bit), busy=1.
  - next cycle: sout=id.
  - next 4 cycles: d3, d2, d1, d0.
  - following cycle: sout=0 (GAP).
  - next edge: returns to IDLE, where a new request can be sampled.
- Frame period is 8 cycles for back-to-back words; 7 cycles from the grant edge to the first edge back in IDLE.
- gnt is high exactly in the start-bit cycle. The requester sees gnt before the next sample point, so no double grant is possible.
- Reset mid-frame: the next cycle shows the reset values on all outputs. The partially sent word is dropped, no gnt is reissued, and `last` returns to 1.
- reset low together with a request: reset wins and no gnt is issued.

## Test plan
- Reset then idle, en=1, no requests for 10 cycles -> sout=0, frame=0, busy=0, gnt0=gnt1=0 throughout.
- req0=1, data0=4'b1011 alone -> gnt0 for 1 cycle; sout sequence 1,0,1,0,1,1 then 0 in GAP; frame high exactly 6 cycles.
- req0 and req1 both held, data0=4'hA, data1=4'h5 -> frames with id 0,1,0,1 in that order, 8-cycle period, gnt pulses alternate.
- en toggled 1,0,1,0 during a frame of data1=4'b1100 -> each bit held for 2 cycles; bit order and id=1 preserved; gnt1 is one cycle only.
- reset asserted in the 3rd data bit of a frame -> next cycle all outputs at reset values; with req1 still high, the next grant after reset release goes to requester 1 only if req0=0, else to requester 0.
- req1 arrives alone while requester 0 is mid-frame -> no gnt until the state returns to IDLE; then gnt1 and an id=1 frame start exactly 8 cycles after the previous start bit.
